// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, operand select, ALU, branch-target add and
// destination select, all captured in the EX/MEM pipeline register.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic [3:0]  ex_ctl,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic [1:0]  wb_ctlout,
  output logic        branch,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] SEL_AND  = 3'b000;
  localparam logic [SW-1:0] SEL_OR   = 3'b001;
  localparam logic [SW-1:0] SEL_ADD  = 3'b010;
  localparam logic [SW-1:0] SEL_NONE = 3'b011;
  localparam logic [SW-1:0] SEL_SUB  = 3'b110;
  localparam logic [SW-1:0] SEL_SLT  = 3'b111;

  logic          reg_dst;
  logic [1:0]    alu_op;
  logic          alu_src;
  logic [5:0]    funct;

  assign reg_dst = ex_ctl[3];
  assign alu_op  = ex_ctl[2:1];
  assign alu_src = ex_ctl[0];
  assign funct   = s_extend[5:0];

  logic [SW-1:0] alu_sel;
  logic [DW-1:0] opnd_b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] br_target;
  logic [RW-1:0] dst_reg;

  // ALU control decode from ALUOp and funct
  always_comb begin
    alu_sel = SEL_NONE;
    unique case (alu_op)
      2'b00: alu_sel = SEL_ADD;
      2'b01: alu_sel = SEL_SUB;
      2'b10: begin
        unique case (funct)
          6'b100000: alu_sel = SEL_ADD;
          6'b100010: alu_sel = SEL_SUB;
          6'b100100: alu_sel = SEL_AND;
          6'b100101: alu_sel = SEL_OR;
          6'b101010: alu_sel = SEL_SLT;
          default:   alu_sel = SEL_NONE;
        endcase
      end
      default: alu_sel = SEL_NONE;
    endcase
  end

  assign opnd_b = alu_src ? s_extend : rdata2;

  // ALU; undefined selects yield zero
  always_comb begin
    alu_res = '0;
    unique case (alu_sel)
      SEL_AND: alu_res = rdata1 & opnd_b;
      SEL_OR:  alu_res = rdata1 | opnd_b;
      SEL_ADD: alu_res = rdata1 + opnd_b;
      SEL_SUB: alu_res = rdata1 - opnd_b;
      SEL_SLT: alu_res = ($signed(rdata1) < $signed(opnd_b)) ? DW'(1) : DW'(0);
      default: alu_res = '0;
    endcase
  end

  assign br_target = npc + {s_extend[DW-3:0], 2'b00};
  assign dst_reg   = reg_dst ? instr_1511 : instr_2016;

  logic [1:0]    wb_q,     wb_d;
  logic [2:0]    m_q,      m_d;
  logic [DW-1:0] add_q,    add_d;
  logic          zero_q,   zero_d;
  logic [DW-1:0] alu_q,    alu_d;
  logic [DW-1:0] rd2_q,    rd2_d;
  logic [RW-1:0] mux_q,    mux_d;

  assign wb_d   = wb_ctl;
  assign m_d    = m_ctl;
  assign add_d  = br_target;
  assign zero_d = (alu_res == '0);
  assign alu_d  = alu_res;
  assign rd2_d  = rdata2;
  assign mux_d  = dst_reg;

  // EX/MEM pipeline register; reset clears everything into a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q   <= '0;
      m_q    <= '0;
      add_q  <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      rd2_q  <= '0;
      mux_q  <= '0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      add_q  <= add_d;
      zero_q <= zero_d;
      alu_q  <= alu_d;
      rd2_q  <= rd2_d;
      mux_q  <= mux_d;
    end
  end

  assign wb_ctlout  = wb_q;
  assign branch     = m_q[2];
  assign memread    = m_q[1];
  assign memwrite   = m_q[0];
  assign add_result = add_q;
  assign zero       = zero_q;
  assign alu_result = alu_q;
  assign rdata2out  = rd2_q;
  assign muxout     = mux_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// compared against a behavioural model of the execute stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0]  instr_2016, instr_1511;
  logic [1:0]  wb_ctlout;
  logic        branch, memread, memwrite, zero;
  logic [31:0] add_result, alu_result, rdata2out;
  logic [4:0]  muxout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl),
    .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .instr_2016(instr_2016), .instr_1511(instr_1511),
    .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
    .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .muxout(muxout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU written directly from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        if (fn == 6'd32) return a + b;
        if (fn == 6'd34) return a - b;
        if (fn == 6'd36) return a & b;
        if (fn == 6'd37) return a | b;
        if (fn == 6'd42) return (sa < sb) ? 32'd1 : 32'd0;
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Drive one instruction, clock it, and check every output against the model
  task automatic apply(input logic rst, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex, input logic [31:0] n, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] se,
                       input logic [4:0] rt, input logic [4:0] rd);
    logic [31:0] b, e_alu, e_add;
    reset = rst; wb_ctl = wb; m_ctl = m; ex_ctl = ex; npc = n;
    rdata1 = r1; rdata2 = r2; s_extend = se; instr_2016 = rt; instr_1511 = rd;
    b     = ex[0] ? se : r2;
    e_alu = ref_alu(ex[2:1], se[5:0], r1, b);
    e_add = n + se * 32'd4;
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_wb", 32'(wb_ctlout), 32'd0);
      chk("rst_m", {29'd0, branch, memread, memwrite}, 32'd0);
      chk("rst_add", add_result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_alu", alu_result, 32'd0);
      chk("rst_rd2", rdata2out, 32'd0);
      chk("rst_mux", 32'(muxout), 32'd0);
    end else begin
      chk("wb", 32'(wb_ctlout), 32'(wb));
      chk("branch", 32'(branch), 32'(m[2]));
      chk("memread", 32'(memread), 32'(m[1]));
      chk("memwrite", 32'(memwrite), 32'(m[0]));
      chk("add_result", add_result, e_add);
      chk("zero", 32'(zero), (e_alu == 32'd0) ? 32'd1 : 32'd0);
      chk("alu_result", alu_result, e_alu);
      chk("rdata2out", rdata2out, r2);
      chk("muxout", 32'(muxout), 32'(ex[3] ? rd : rt));
    end
  endtask

  initial begin
    logic [5:0] fsweep [5];
    logic [31:0] esweep [5];
    logic [5:0] legal [5];
    logic [31:0] se;
    fsweep = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    esweep = '{32'hD, 32'h7, 32'h2, 32'hB, 32'h0};
    legal  = fsweep;

    // Reset with all inputs non-zero
    apply(1'b1, 2'b11, 3'b111, 4'b1111, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0,
          32'h0000_0FFF, 5'd31, 5'd30);
    // First R-type add right after reset release
    apply(1'b0, 2'b10, 3'b000, 4'b1100, 32'h4, 32'hA, 32'h3, 32'h0000_0020, 5'd2, 5'd8);
    chk("post_rst_add", alu_result, 32'hD);

    // R-type funct sweep
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hA, 32'h3, 32'(fsweep[i]), 5'd3, 5'd8);
      chk("rtype_const", alu_result, esweep[i]);
      chk("rtype_mux", 32'(muxout), 32'd8);
    end

    // Signed slt and undefined funct
    apply(1'b0, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hFFFF_FFFF, 32'h1, 32'h2A, 5'd1, 5'd4);
    chk("slt_signed", alu_result, 32'd1);
    chk("slt_zero", 32'(zero), 32'd0);
    apply(1'b0, 2'b10, 3'b000, 4'b1100, 32'h8, 32'hA, 32'h3, 32'h0, 5'd1, 5'd4);
    chk("undef_funct", alu_result, 32'd0);
    chk("undef_zero", 32'(zero), 32'd1);

    // lw/sw address computation
    apply(1'b0, 2'b11, 3'b010, 4'b0001, 32'h10, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC,
          5'd9, 5'd1);
    chk("lw_addr", alu_result, 32'hFC);
    chk("lw_mux", 32'(muxout), 32'd9);
    chk("lw_memread", 32'(memread), 32'd1);
    chk("lw_store", rdata2out, 32'hDEAD_BEEF);

    // beq taken / not taken
    apply(1'b0, 2'b00, 3'b100, 4'b0010, 32'h40, 32'h55, 32'h55, 32'hFFFF_FFFE, 5'd0, 5'd0);
    chk("beq_zero", 32'(zero), 32'd1);
    chk("beq_target", add_result, 32'h38);
    chk("beq_branch", 32'(branch), 32'd1);
    apply(1'b0, 2'b00, 3'b100, 4'b0010, 32'h40, 32'h55, 32'h56, 32'hFFFF_FFFE, 5'd0, 5'd0);
    chk("bne_zero", 32'(zero), 32'd0);

    // Back-to-back distinct instructions including add wrap
    apply(1'b0, 2'b10, 3'b001, 4'b1100, 32'h100, 32'h7, 32'h5, 32'h22, 5'd6, 5'd7);
    apply(1'b0, 2'b01, 3'b000, 4'b0000, 32'h104, 32'hFFFF_FFFF, 32'h1, 32'h3, 5'd10, 5'd11);
    chk("wrap_alu", alu_result, 32'd0);
    chk("wrap_zero", 32'(zero), 32'd1);
    apply(1'b0, 2'b11, 3'b010, 4'b0001, 32'h108, 32'h20, 32'h77, 32'h10, 5'd12, 5'd13);
    apply(1'b0, 2'b00, 3'b100, 4'b0010, 32'h10C, 32'h3, 32'h9, 32'h1, 5'd14, 5'd15);

    // Mid-stream reset drops the in-flight instruction
    apply(1'b1, 2'b11, 3'b111, 4'b1101, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 5'd6);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      se = $urandom;
      if ($urandom_range(0, 1) == 0) se[5:0] = legal[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) se = 32'(signed'(16'($urandom)));
      apply(($urandom_range(0, 9) == 0), 2'($urandom), 3'($urandom), 4'($urandom),
            $urandom, ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom,
            ($urandom_range(0, 4) == 0) ? 32'h1 : $urandom, se,
            5'($urandom), 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
